// File: rtl/wt_code_pkg.sv
// Shared letter-code definitions for the WT display path (encoder and decoder).
// Codes 0..11 name the twelve displayable letters; CODE_BLANK drives a blank cell.
package wt_code_pkg;

  localparam logic [4:0] CODE_G     = 5'd0;
  localparam logic [4:0] CODE_T     = 5'd1;
  localparam logic [4:0] CODE_W     = 5'd2;
  localparam logic [4:0] CODE_O     = 5'd3;
  localparam logic [4:0] CODE_B     = 5'd4;
  localparam logic [4:0] CODE_U     = 5'd5;
  localparam logic [4:0] CODE_A     = 5'd6;
  localparam logic [4:0] CODE_L     = 5'd7;
  localparam logic [4:0] CODE_N     = 5'd8;
  localparam logic [4:0] CODE_I     = 5'd9;
  localparam logic [4:0] CODE_C     = 5'd10;
  localparam logic [4:0] CODE_K     = 5'd11;
  localparam logic [4:0] CODE_BLANK = 5'd31;

  localparam logic [7:0] ASC_G     = 8'h47;
  localparam logic [7:0] ASC_T     = 8'h54;
  localparam logic [7:0] ASC_W     = 8'h57;
  localparam logic [7:0] ASC_O     = 8'h4F;
  localparam logic [7:0] ASC_B     = 8'h42;
  localparam logic [7:0] ASC_U     = 8'h55;
  localparam logic [7:0] ASC_J_LC  = 8'h6A;
  localparam logic [7:0] ASC_A     = 8'h41;
  localparam logic [7:0] ASC_L     = 8'h4C;
  localparam logic [7:0] ASC_N     = 8'h4E;
  localparam logic [7:0] ASC_I     = 8'h49;
  localparam logic [7:0] ASC_C     = 8'h43;
  localparam logic [7:0] ASC_K     = 8'h4B;
  localparam logic [7:0] ASC_SPACE = 8'h20;

  // One FIFO entry / lookup result.
  typedef struct packed {
    logic       err;
    logic [4:0] code;
  } lut_res_t;

endpackage

// File: rtl/wt_char_lut.sv
// Combinational ASCII byte -> {err, 5-bit letter code} lookup.
// Optional feature macro: WT_CASE_FOLD_EN folds lowercase letters to uppercase
// before the lookup (0x6A keeps its own alias and is never folded).
module wt_char_lut
  import wt_code_pkg::*;
(
  input  logic [7:0] i_char,
  output lut_res_t   o_res
);

  logic [7:0] w_char;

  // Optional case fold, then table lookup; unmapped bytes give blank with err.
  always_comb begin
    w_char = i_char;
`ifdef WT_CASE_FOLD_EN
    if ((i_char >= 8'h61) && (i_char <= 8'h7A) && (i_char != ASC_J_LC))
      w_char = i_char - 8'h20;
`else
`endif
    o_res.code = CODE_BLANK;
    o_res.err  = 1'b1;
    case (w_char)
      ASC_G:     begin o_res.code = CODE_G;     o_res.err = 1'b0; end
      ASC_T:     begin o_res.code = CODE_T;     o_res.err = 1'b0; end
      ASC_W:     begin o_res.code = CODE_W;     o_res.err = 1'b0; end
      ASC_O:     begin o_res.code = CODE_O;     o_res.err = 1'b0; end
      ASC_B:     begin o_res.code = CODE_B;     o_res.err = 1'b0; end
      ASC_U:     begin o_res.code = CODE_U;     o_res.err = 1'b0; end
      ASC_J_LC:  begin o_res.code = CODE_U;     o_res.err = 1'b0; end
      ASC_A:     begin o_res.code = CODE_A;     o_res.err = 1'b0; end
      ASC_L:     begin o_res.code = CODE_L;     o_res.err = 1'b0; end
      ASC_N:     begin o_res.code = CODE_N;     o_res.err = 1'b0; end
      ASC_I:     begin o_res.code = CODE_I;     o_res.err = 1'b0; end
      ASC_C:     begin o_res.code = CODE_C;     o_res.err = 1'b0; end
      ASC_K:     begin o_res.code = CODE_K;     o_res.err = 1'b0; end
      ASC_SPACE: begin o_res.code = CODE_BLANK; o_res.err = 1'b0; end
      default:   begin o_res.code = CODE_BLANK; o_res.err = 1'b1; end
    endcase
  end

endmodule

// File: rtl/wt_encoder_english.sv
// Streaming ASCII-to-letter-code encoder with output FIFO and saturating
// unmappable-byte counter. Optional feature macro: WT_CASE_FOLD_EN (see wt_char_lut).
module wt_encoder_english
  import wt_code_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ERRCNT_W   = 8
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic [7:0]          IN_CHAR,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic [4:0]          OUT_CODE,
  output logic                OUT_ERR,
  input  logic                CLR_ERR,
  output logic [ERRCNT_W-1:0] ERR_CNT
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  lut_res_t              w_lut;
  lut_res_t              r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr;
  logic [AW-1:0]         r_rd;
  logic [AW:0]           r_count;
  logic [ERRCNT_W-1:0]   r_err_cnt;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_err_inc;

  wt_char_lut u_lut (
    .i_char (IN_CHAR),
    .o_res  (w_lut)
  );

  // Ready depends only on stored count and reset, never on IN_VALID.
  assign IN_READY  = RST_N && (r_count < DEPTH_C);
  assign OUT_VALID = (r_count != '0);
  assign OUT_CODE  = OUT_VALID ? r_mem[r_rd].code : CODE_BLANK;
  assign OUT_ERR   = OUT_VALID ? r_mem[r_rd].err  : 1'b0;
  assign ERR_CNT   = r_err_cnt;

  assign w_push    = IN_VALID && IN_READY;
  assign w_pop     = OUT_VALID && OUT_READY;
  assign w_err_inc = w_push && w_lut.err;

  // FIFO pointers and occupancy; power-of-2 depth lets pointers wrap naturally.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  // FIFO storage; contents are masked by the count so no reset is needed.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr] <= w_lut;
  end

  // Saturating error counter; a clear coinciding with an error leaves it at one.
  always_ff @(posedge CLK) begin
    if (!RST_N)
      r_err_cnt <= '0;
    else if (CLR_ERR)
      r_err_cnt <= ERRCNT_W'(w_err_inc);
    else if (w_err_inc && (r_err_cnt != '1))
      r_err_cnt <= r_err_cnt + 1'b1;
  end

endmodule

// File: tb/tb_wt_encoder_english.sv
// Self-checking bench for wt_encoder_english: directed scenarios plus random
// traffic, all checked against a queue-based reference model.
module tb_wt_encoder_english;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned CW      = 2;
  localparam int unsigned CNT_MAX = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          IN_VALID;
  logic          IN_READY;
  logic [7:0]    IN_CHAR;
  logic          OUT_VALID;
  logic          OUT_READY;
  logic [4:0]    OUT_CODE;
  logic          OUT_ERR;
  logic          CLR_ERR;
  logic [CW-1:0] ERR_CNT;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  int          q_code[$];
  bit          q_err[$];
  int unsigned m_cnt;

  always #5 CLK = ~CLK;

  wt_encoder_english #(.FIFO_DEPTH(DEPTH), .ERRCNT_W(CW)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_CHAR   (IN_CHAR),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_CODE  (OUT_CODE),
    .OUT_ERR   (OUT_ERR),
    .CLR_ERR   (CLR_ERR),
    .ERR_CNT   (ERR_CNT)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference mapping: letter position in "GTWOBUALNICK" is its code.
  function automatic void ref_map(input logic [7:0] c, output int code, output bit err);
    string      s = "GTWOBUALNICK";
    logic [7:0] u = c;
    code = 31;
    err  = 1'b1;
    if (c == 8'h6A) begin code = 5; err = 1'b0; return; end
    if (c == 8'h20) begin code = 31; err = 1'b0; return; end
`ifdef WT_CASE_FOLD_EN
    if (c >= 8'h61 && c <= 8'h7A) u = c - 8'h20;
`endif
    for (int i = 0; i < 12; i++)
      if (s[i] == u) begin code = i; err = 1'b0; end
  endfunction

  // One clock: drive inputs, check outputs against the model, advance the model.
  task automatic step(input bit rst_n, input bit v, input logic [7:0] ch,
                      input bit ordy, input bit clr);
    bit exp_rdy, push, pop, e;
    int c;
    @(negedge CLK);
    RST_N = rst_n; IN_VALID = v; IN_CHAR = ch; OUT_READY = ordy; CLR_ERR = clr;
    #1;
    exp_rdy = rst_n && (q_code.size() < DEPTH);
    check("in_ready",  32'(IN_READY),  32'(exp_rdy));
    check("out_valid", 32'(OUT_VALID), 32'(q_code.size() != 0));
    check("out_code",  32'(OUT_CODE),  (q_code.size() != 0) ? 32'(q_code[0]) : 32'd31);
    check("out_err",   32'(OUT_ERR),   (q_code.size() != 0) ? 32'(q_err[0]) : 32'd0);
    check("err_cnt",   32'(ERR_CNT),   32'(m_cnt));
    push = v && exp_rdy;
    pop  = (q_code.size() != 0) && ordy;
    ref_map(ch, c, e);
    @(posedge CLK);
    if (!rst_n) begin
      q_code.delete(); q_err.delete(); m_cnt = 0;
    end else begin
      if (pop) begin void'(q_code.pop_front()); void'(q_err.pop_front()); end
      if (push) begin q_code.push_back(c); q_err.push_back(e); end
      if (clr) m_cnt = (push && e) ? 1 : 0;
      else if (push && e && m_cnt < CNT_MAX) m_cnt++;
    end
  endtask

  initial begin
    string   word = "GTWOBUALNICK";
    logic [7:0] ch;
    RST_N = 1'b0; IN_VALID = 1'b0; IN_CHAR = '0; OUT_READY = 1'b0; CLR_ERR = 1'b0;
    m_cnt = 0;
    repeat (2) @(posedge CLK);
    step(0, 0, 8'h00, 0, 0);

    // Reference stream, consumer always ready.
    for (int i = 0; i < 12; i++) step(1, 1, word[i], 1, 0);
    step(1, 0, 8'h00, 1, 0);
    step(1, 0, 8'h00, 1, 0);

    // Back-pressure: fifth byte refused until a pop frees a slot.
    for (int i = 0; i < 5; i++) step(1, 1, 8'h41, 0, 0);
    check("full_ready", 32'(IN_READY), 32'd0);
    step(1, 1, 8'h55, 1, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 8'h00, 1, 0);

    // Space, lowercase-j alias, unmapped '?'.
    step(1, 1, 8'h20, 1, 0);
    step(1, 1, 8'h6A, 1, 0);
    step(1, 1, 8'h3F, 1, 0);
    step(1, 0, 8'h00, 1, 0);
    step(1, 0, 8'h00, 1, 0);

    // Saturation, then clear coinciding with another error.
    for (int i = 0; i < 5; i++) step(1, 1, 8'h3F, 1, 0);
    step(1, 1, 8'h3F, 1, 1);
    step(1, 0, 8'h00, 1, 0);
    check("clr_then_count", 32'(ERR_CNT), 32'd1);

    // Mid-stream reset discards the FIFO.
    for (int i = 0; i < 3; i++) step(1, 1, 8'h41, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    step(1, 1, 8'h4B, 0, 0);
    step(1, 0, 8'h00, 1, 0);
    step(1, 0, 8'h00, 1, 0);

    // Lowercase handling (expectation follows the build's fold setting).
    step(1, 1, 8'h67, 1, 0);
    step(1, 1, 8'h6A, 1, 0);
    step(1, 1, 8'h7A, 1, 0);
    step(1, 0, 8'h00, 1, 0);
    step(1, 0, 8'h00, 1, 0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 3))
        0: begin ch = word[$urandom_range(0, 11)]; end
        1: ch = ($urandom_range(0, 1) != 0) ? 8'h20 : 8'h6A;
        2: ch = 8'(8'h61 + $urandom_range(0, 25));
        default: ch = 8'($urandom_range(0, 255));
      endcase
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0), ch,
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
    end
    step(1, 0, 8'h00, 1, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
